// File: rtl/pipe_addsub_n_pkg.sv
// Shared types for the pipelined add/subtract unit.
//   op_e           : operation select carried with each beat
//   addsub_flags_t : carry / signed-overflow / zero result flags
//   DEF_N, DEF_CHUNK : default width and per-stage slice width
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,  // a + b + ci
        OP_SUB = 1'b1   // a - b
    } op_e;

    typedef struct packed {
        logic co;
        logic ov;
        logic zero;
    } addsub_flags_t;

    localparam int DEF_N     = 16;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/pipe_addsub_n_slice.sv
// Combinational ripple-carry building blocks.
//   full_adder_1 : a_i, b_i, ci_i -> s_o, co_o (one bit)
//   addsub_slice : W-bit ripple chain of full_adder_1 cells
//                  a_i[W], b_i[W], ci_i -> s_o[W], co_o
module full_adder_1 (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);
    logic [W:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder_1 u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (c[i]),
            .s_o  (s_o[i]),
            .co_o (c[i+1])
        );
    end

    assign co_o = c[W];
endmodule

// File: rtl/pipe_addsub_n.sv
// Pipelined N-bit add/subtract, one CHUNK-bit ripple slice per register stage.
// The carry and the unconsumed operand bits move one stage per cycle, so each
// slice adds in its own cycle; finished low slices travel alongside.
// Ports:
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (a, b, ci, op sampled on transfer)
//   out_valid / out_ready: result handshake (s, co, ov, zero)
// Latency is STAGES = N/CHUNK cycles; a single global advance enable stalls
// the whole pipe when the output is held.
module pipe_addsub_n
    import adder_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ov,
    output logic         zero
);
    localparam int STAGES = N / CHUNK;
    localparam int L      = STAGES - 1;
    // Inter-stage operand/carry registers exist only between stages.
    localparam int P      = (STAGES > 1) ? STAGES - 1 : 1;

    if (N % CHUNK != 0) begin : g_bad_cfg
        $error("pipe_addsub_n: N must be a multiple of CHUNK");
    end

    logic adv, take, rdy_q;

    logic [STAGES-1:0]                 vld_q;
    logic [STAGES-1:0][N-1:0]          s_q;
    logic [P-1:0][N-1:0]               a_q, b_q;
    logic [P-1:0]                      c_q;

    logic [STAGES-1:0][N-1:0]          a_in, b_in, s_in, s_nx;
    logic [STAGES-1:0]                 c_in;
    logic [STAGES-1:0][CHUNK-1:0]      sl_s;
    logic [STAGES-1:0]                 sl_c;

    addsub_flags_t flg_d, flg_q;

    // Whole pipe moves together; it only stops when a result is held.
    assign adv      = !vld_q[L] || out_ready;
    // rdy_q keeps the unit closed during reset and for the first cycle after.
    assign in_ready = adv && rdy_q;
    assign take     = in_valid && in_ready;

    always_comb begin
        a_in = '0;
        b_in = '0;
        c_in = '0;
        s_in = '0;
        s_nx = '0;
        // Subtract as a + ~b + 1.
        a_in[0] = a;
        b_in[0] = (op_e'(op) == OP_SUB) ? ~b : b;
        c_in[0] = (op_e'(op) == OP_SUB) ? 1'b1 : ci;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_in[k];
            s_nx[k][k*CHUNK +: CHUNK] = sl_s[k];
        end
        // Flags use the fully assembled result of the last slice.
        flg_d.co   = sl_c[L];
        flg_d.ov   = (a_in[L][N-1] == b_in[L][N-1]) && (s_nx[L][N-1] != a_in[L][N-1]);
        flg_d.zero = (s_nx[L] == '0);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        addsub_slice #(.W(CHUNK)) u_slice (
            .a_i  (a_in[k][k*CHUNK +: CHUNK]),
            .b_i  (b_in[k][k*CHUNK +: CHUNK]),
            .ci_i (c_in[k]),
            .s_o  (sl_s[k]),
            .co_o (sl_c[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
            vld_q <= '0;
            s_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            flg_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (adv) begin
                vld_q[0] <= take;
                for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
                for (int k = 0; k < STAGES - 1; k++) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    c_q[k] <= sl_c[k];
                end
                s_q   <= s_nx;
                flg_q <= flg_d;
            end
        end
    end

    assign out_valid = vld_q[L];
    assign s         = s_q[L];
    assign co        = flg_q.co;
    assign ov        = flg_q.ov;
    assign zero      = flg_q.zero;

endmodule
